data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache that is the responder on the CPU data-memory interface. It services word-aligned loads and stores, with byte enables, issued by the pipeline's memory stage. Misses are filled from a line-wide physical-memory port. It sits between the core's `d_mem_*` bus and the memory arbiter.

## Interface
Parameters:
- `S_INDEX`, default 3: index bits; the cache has 2^S_INDEX sets.
- `S_OFFSET`, default 5: offset bits; lines are 32 bytes. Only 5 is supported.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `mem_addr`  in  32  CPU word address; bits [1:0] are ignored.
- `mem_read`  in  1  load request; held until `mem_resp`.
- `mem_write`  in  1  store request; held until `mem_resp`.
- `mem_wdata`  in  32  store data, already lane-shifted.
- `mem_byte_enable`  in  4  store lane mask.
- `mem_rdata`  out  32  load data word.
- `mem_resp`  out  1  one-cycle completion pulse.
- `pmem_address`  out  32  line address, low 5 bits zero.
- `pmem_read`  out  1  line-fill request.
- `pmem_write`  out  1  line-writeback request.
- `pmem_wdata`  out  256  victim line.
- `pmem_rdata`  in  256  fill line.
- `pmem_resp`  in  1  one-cycle completion of a `pmem_read` or `pmem_write`.

## Operation
- Address split: tag = `mem_addr[31:S_INDEX+5]`, index = `[S_INDEX+4:5]`, word select = `[4:2]`.
- Per-set state: valid, dirty, tag, 256-bit data.
- FSM states:
  - IDLE: compare tag. On a hit with `mem_read` or `mem_write`, assert `mem_resp` combinationally in the same cycle and stay in IDLE.
  - IDLE on a miss: go to WRITEBACK if the victim is valid and dirty, otherwise go to ALLOCATE.
  - WRITEBACK: hold `pmem_write`=1, `pmem_address`={victim tag, index, 5'b0}, `pmem_wdata`=victim line. On `pmem_resp`, go to ALLOCATE.
  - ALLOCATE: hold `pmem_read`=1, `pmem_address`={req tag, index, 5'b0}. On `pmem_resp`, write the line, set valid, clear dirty, load the tag, and go to IDLE. The request then hits in the next cycle.
- Read hit: `mem_rdata` = the selected 32-bit word of the line. Sub-word extraction is done by the CPU.
- Write hit: on the clock edge where `mem_resp`=1, update only the bytes whose `mem_byte_enable` bit is set, and set dirty.
- `mem_rdata` is valid only while `mem_resp`=1; it is don't-care otherwise.
- `mem_read` and `mem_write` asserted together is a protocol violation. Treat it as a write and fire a simulation-only error.

## Timing
- Hit latency: 0 cycles. `mem_resp` is asserted in the first cycle the request is seen in IDLE.
- Clean miss: ALLOCATE for N cycles until `pmem_resp`, then 1 cycle in IDLE with `mem_resp`.
- Dirty miss: WRITEBACK, then ALLOCATE, then IDLE hit.
- `pmem_read` and `pmem_write` are never both 1. They are asserted from state decode and stay stable until `pmem_resp`.
- `pmem_resp` arriving in IDLE is ignored.
- The CPU must hold the request through a miss. If the request drops mid-miss, the fill/writeback still completes and the FSM returns to IDLE; no `mem_resp` is issued.
- Reset, asynchronous at `rst`=0:
  - state goes to IDLE; all valid and dirty bits clear.
  - `mem_resp`, `pmem_read` and `pmem_write` go to 0 immediately, including in the middle of a miss.
  - tag and data arrays are not reset.
- A store to a line in the same cycle as its fill cannot happen: the store waits for the IDLE hit.

## Structure
- Package `cache_types`:
  - state enum `{IDLE, WRITEBACK, ALLOCATE}`
  - line width 256
  - `TAG_W` = 32 − S_INDEX − 5
- Sub-module `cache_array`: parameterised-width, 2^S_INDEX-entry register array.
  - asynchronous read, synchronous write, active-low async reset.
  - Instantiated for valid, dirty, tag and data.
  - The data instance takes a 32-byte write-enable mask.
- `data_cache` contains the FSM, hit logic and datapath muxes.

## Test plan
- Cold load of 0x0000_1004 → ALLOCATE with `pmem_address`=0x0000_1000; return a line whose word 1 = 0xDEAD_BEEF; next cycle `mem_resp`=1 and `mem_rdata`=0xDEAD_BEEF.
- Repeat load of 0x0000_1004 → `mem_resp`=1 in the same cycle; no `pmem_read`.
- Store 0x0000_AB00 with byte_enable 4'b0010 to 0x0000_1004 → single-cycle resp; a reload returns 0xDEAD_ABEF and the set is dirty.
- Load 0x0000_2004 (same index, S_INDEX=3, new tag) → WRITEBACK to 0x0000_1000 with word 1 = 0xDEAD_ABEF, then ALLOCATE at 0x0000_2000, then resp.
- Assert `rst`=0 while in ALLOCATE → `pmem_read` drops that cycle; after release, a load of 0x0000_2004 misses again.
- Stall `pmem_resp` for 20 cycles → `pmem_address` and `pmem_read` stay stable and `mem_resp` stays 0 throughout.

Source files
------------

// File: rtl/cache_types.sv
// rtl/cache_types.sv - shared state encoding and widths for the data cache
package cache_types;

   // Controller states: compare in IDLE, evict in WRITEBACK, fill in ALLOCATE
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   localparam int LINE_W      = 256;
   localparam int WORD_W      = 32;
   localparam int LINE_BYTES  = LINE_W / 8;
   localparam int LINE_WORDS  = LINE_W / WORD_W;
   localparam int DEF_S_INDEX = 3;
   localparam int TAG_W       = 32 - DEF_S_INDEX - 5;

   // Tag width for a given number of index bits with 32-byte lines
   function automatic int tag_width(input int s_index);
      return 32 - s_index - 5;
   endfunction

endpackage

// File: rtl/cache_array.sv
// rtl/cache_array.sv - per-set register array with async read and lane write enables
module cache_array #(
   parameter int WIDTH    = 1,
   parameter int S_INDEX  = 3,
   parameter int LANES    = 1,
   parameter bit RESET_EN = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [S_INDEX-1:0] i_index,
   input  logic [LANES-1:0]   i_we,
   input  logic [WIDTH-1:0]   i_wdata,
   output logic [WIDTH-1:0]   o_rdata
);

   localparam int DEPTH  = 1 << S_INDEX;
   localparam int LANE_W = WIDTH / LANES;

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Reads are combinational so hit detection happens in the request cycle
   assign o_rdata = r_mem[i_index];

   generate
      if (RESET_EN) begin : g_rst
         // Status bits: cleared on reset so every set starts out empty
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int e = 0; e < DEPTH; e++) begin
                  r_mem[e] <= '0;
               end
            end else begin
               for (int l = 0; l < LANES; l++) begin
                  if (i_we[l]) r_mem[i_index][l*LANE_W +: LANE_W] <= i_wdata[l*LANE_W +: LANE_W];
               end
            end
         end
      end else begin : g_nrst
         logic w_unused_rst_n;
         assign w_unused_rst_n = rst_n;

         // Tag/data storage: contents are meaningless until the valid bit is set
         always_ff @(posedge clk) begin
            for (int l = 0; l < LANES; l++) begin
               if (i_we[l]) r_mem[i_index][l*LANE_W +: LANE_W] <= i_wdata[l*LANE_W +: LANE_W];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate data cache
module data_cache
   import cache_types::*;
#(
   parameter int S_INDEX  = 3,
   parameter int S_OFFSET = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         mem_addr,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [31:0]         mem_wdata,
   input  logic [3:0]          mem_byte_enable,
   output logic [31:0]         mem_rdata,
   output logic                mem_resp,
   output logic [31:0]         pmem_address,
   output logic                pmem_read,
   output logic                pmem_write,
   output logic [LINE_W-1:0]   pmem_wdata,
   input  logic [LINE_W-1:0]   pmem_rdata,
   input  logic                pmem_resp
);

   localparam int W_TAG  = tag_width(S_INDEX);
   localparam int W_WSEL = S_OFFSET - 2;
   localparam logic [S_OFFSET-1:0] OFF_ZERO = '0;

   state_t               r_state;
   logic [W_TAG-1:0]     r_req_tag;
   logic [S_INDEX-1:0]   r_idx;
   logic                 r_pmem_read;
   logic                 r_pmem_write;
   logic [31:0]          r_pmem_address;

   logic [W_TAG-1:0]     w_req_tag;
   logic [S_INDEX-1:0]   w_req_idx;
   logic [W_WSEL-1:0]    w_wsel;
   logic [S_INDEX-1:0]   w_idx;
   logic                 w_valid;
   logic                 w_dirty;
   logic [W_TAG-1:0]     w_tag;
   logic [LINE_W-1:0]    w_line;
   logic                 w_req;
   logic                 w_hit;
   logic                 w_resp;
   logic                 w_fill;
   logic                 w_store;
   logic [LINE_BYTES-1:0] w_data_we;
   logic [LINE_W-1:0]    w_data_wdata;
   logic                 w_dirty_we;
   logic [1:0]           w_unused_addr;

   assign w_req_tag     = mem_addr[31 -: W_TAG];
   assign w_req_idx     = mem_addr[S_INDEX+S_OFFSET-1 : S_OFFSET];
   assign w_wsel        = mem_addr[S_OFFSET-1 : 2];
   assign w_unused_addr = mem_addr[1:0];

   // Outside IDLE the arrays are addressed by the latched miss, not the live bus
   assign w_idx   = (r_state == IDLE) ? w_req_idx : r_idx;

   assign w_req   = mem_read | mem_write;
   assign w_hit   = w_valid && (w_tag == w_req_tag);
   assign w_resp  = (r_state == IDLE) && w_req && w_hit;
   assign w_fill  = (r_state == ALLOCATE) && pmem_resp;
   // A simultaneous read and write is handled as a write
   assign w_store = w_resp && mem_write;

   // Fills replace the whole line; stores touch only their enabled byte lanes
   assign w_data_we    = w_fill  ? {LINE_BYTES{1'b1}} :
                         w_store ? (LINE_BYTES'(mem_byte_enable) << {w_wsel, 2'b00}) :
                                   {LINE_BYTES{1'b0}};
   assign w_data_wdata = w_fill ? pmem_rdata : {LINE_WORDS{mem_wdata}};
   assign w_dirty_we   = w_fill | w_store;

   cache_array #(.WIDTH(1), .S_INDEX(S_INDEX), .LANES(1), .RESET_EN(1'b1)) u_valid (
      .clk     (clk),
      .rst_n   (rst),
      .i_index (w_idx),
      .i_we    (w_fill),
      .i_wdata (1'b1),
      .o_rdata (w_valid)
   );

   cache_array #(.WIDTH(1), .S_INDEX(S_INDEX), .LANES(1), .RESET_EN(1'b1)) u_dirty (
      .clk     (clk),
      .rst_n   (rst),
      .i_index (w_idx),
      .i_we    (w_dirty_we),
      .i_wdata (w_store),
      .o_rdata (w_dirty)
   );

   cache_array #(.WIDTH(W_TAG), .S_INDEX(S_INDEX), .LANES(1), .RESET_EN(1'b0)) u_tag (
      .clk     (clk),
      .rst_n   (rst),
      .i_index (w_idx),
      .i_we    (w_fill),
      .i_wdata (r_req_tag),
      .o_rdata (w_tag)
   );

   cache_array #(.WIDTH(LINE_W), .S_INDEX(S_INDEX), .LANES(LINE_BYTES), .RESET_EN(1'b0)) u_data (
      .clk     (clk),
      .rst_n   (rst),
      .i_index (w_idx),
      .i_we    (w_data_we),
      .i_wdata (w_data_wdata),
      .o_rdata (w_line)
   );

   assign mem_rdata    = w_line[{w_wsel, 5'b00000} +: WORD_W];
   assign mem_resp     = w_resp;
   assign pmem_address = r_pmem_address;
   assign pmem_read    = r_pmem_read;
   assign pmem_write   = r_pmem_write;
   assign pmem_wdata   = w_line;

   // Miss controller: latches the missing address and holds the memory request until pmem_resp
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= IDLE;
         r_req_tag      <= '0;
         r_idx          <= '0;
         r_pmem_read    <= 1'b0;
         r_pmem_write   <= 1'b0;
         r_pmem_address <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req && !w_hit) begin
                  r_req_tag <= w_req_tag;
                  r_idx     <= w_req_idx;
                  if (w_valid && w_dirty) begin
                     r_state        <= WRITEBACK;
                     r_pmem_write   <= 1'b1;
                     r_pmem_address <= {w_tag, w_req_idx, OFF_ZERO};
                  end else begin
                     r_state        <= ALLOCATE;
                     r_pmem_read    <= 1'b1;
                     r_pmem_address <= {w_req_tag, w_req_idx, OFF_ZERO};
                  end
               end
            end
            WRITEBACK: begin
               if (pmem_resp) begin
                  r_state        <= ALLOCATE;
                  r_pmem_write   <= 1'b0;
                  r_pmem_read    <= 1'b1;
                  r_pmem_address <= {r_req_tag, r_idx, OFF_ZERO};
               end
            end
            ALLOCATE: begin
               if (pmem_resp) begin
                  r_state     <= IDLE;
                  r_pmem_read <= 1'b0;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_pmem_read  <= 1'b0;
               r_pmem_write <= 1'b0;
            end
         endcase
      end
   end

   a_rw_excl: assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write))
      else $error("data_cache: mem_read and mem_write asserted together");

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - self-checking bench for data_cache
module tb_data_cache;

   logic          clk;
   logic          rst;
   logic [31:0]   mem_addr;
   logic          mem_read;
   logic          mem_write;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_byte_enable;
   logic [31:0]   mem_rdata;
   logic          mem_resp;
   logic [31:0]   pmem_address;
   logic          pmem_read;
   logic          pmem_write;
   logic [255:0]  pmem_wdata;
   logic [255:0]  pmem_rdata;
   logic          pmem_resp;

   int total = 0;
   int bad   = 0;
   int resp_delay = 0;
   int wait_cnt = 0;

   // backing physical memory (line granular) and coherent word view of memory
   logic [255:0] pm [logic [31:0]];
   logic [31:0]  cm [logic [31:0]];
   // per-set residency model
   bit           mv [8];
   bit           md [8];
   logic [23:0]  mt [8];

   bit           prev_r;
   bit           prev_w;
   logic [31:0]  prev_a;
   logic [31:0]  cw;

   logic [31:0]  last_rdata;
   logic [31:0]  last_wb_addr;
   logic [31:0]  last_al_addr;
   logic [255:0] last_wb_line;

   data_cache #(.S_INDEX(3), .S_OFFSET(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_addr        (mem_addr),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp),
      .pmem_address    (pmem_address),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_wdata      (pmem_wdata),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
      return {a[31:16] ^ 16'hA5C3, a[15:0]};
   endfunction

   function automatic logic [255:0] fetch_line(input logic [31:0] la);
      logic [255:0] l;
      if (pm.exists(la)) return pm[la];
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + w*4);
      return l;
   endfunction

   function automatic logic [31:0] cm_word(input logic [31:0] a);
      logic [31:0]  k;
      logic [255:0] l;
      k = {a[31:2], 2'b00};
      if (cm.exists(k)) return cm[k];
      l = fetch_line({a[31:5], 5'b00000});
      return l[int'(a[4:2])*32 +: 32];
   endfunction

   function automatic logic [255:0] cm_line(input logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = cm_word(la + w*4);
      return l;
   endfunction

   // physical memory responder with programmable stall
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk); #2;
         pmem_resp = 1'b0;
         if (rst && (pmem_read || pmem_write)) begin
            if (wait_cnt >= resp_delay) begin
               wait_cnt = 0;
               if (pmem_write) pm[pmem_address] = pmem_wdata;
               else pmem_rdata = fetch_line(pmem_address);
               pmem_resp = 1'b1;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // per-cycle compare against the coherent memory model
   initial begin
      prev_r = 1'b0;
      prev_w = 1'b0;
      prev_a = '0;
      forever begin
         @(posedge clk); #7;
         if (rst !== 1'b1) begin
            prev_r = 1'b0;
            prev_w = 1'b0;
         end else begin
            chk("pmem_excl", 256'(pmem_read && pmem_write), 256'(0));
            if (mem_resp) begin
               if (mem_write) begin
                  cw = cm_word(mem_addr);
                  for (int b = 0; b < 4; b++)
                     if (mem_byte_enable[b]) cw[b*8 +: 8] = mem_wdata[b*8 +: 8];
                  cm[{mem_addr[31:2], 2'b00}] = cw;
               end else begin
                  chk("rdata", 256'(mem_rdata), 256'(cm_word(mem_addr)));
               end
            end
            if (pmem_read || pmem_write) chk("pmem_align", 256'(pmem_address[4:0]), 256'(0));
            if ((pmem_read && prev_r) || (pmem_write && prev_w))
               chk("pmem_stable", 256'(pmem_address), 256'(prev_a));
            if (pmem_write) chk("wb_line", pmem_wdata, cm_line(pmem_address));
            prev_r = pmem_read;
            prev_w = pmem_write;
            prev_a = pmem_address;
         end
      end
   end

   // one CPU access; entered and left 2 time units after a rising edge
   task automatic access(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                         input logic [3:0] be, input int dly);
      int          s;
      logic [23:0] t;
      bit          exp_hit;
      bit          exp_wb;
      int          exp_cyc;
      bit          seen_r;
      bit          seen_w;
      bit          done;
      int          cyc;
      s       = int'(a[7:5]);
      t       = a[31:8];
      exp_hit = mv[s] && (mt[s] == t);
      exp_wb  = !exp_hit && mv[s] && md[s];
      exp_cyc = exp_hit ? 0 : 1 + (exp_wb ? 2 : 1) * (dly + 1);
      seen_r  = 1'b0;
      seen_w  = 1'b0;
      done    = 1'b0;
      cyc     = 0;
      last_wb_addr = '0;
      last_al_addr = '0;
      last_wb_line = '0;
      last_rdata   = '0;
      resp_delay      = dly;
      mem_addr        = a;
      mem_read        = !wr;
      mem_write       = wr;
      mem_wdata       = wd;
      mem_byte_enable = be;
      while (!done && cyc < 200) begin
         #5;
         if (pmem_write && !seen_w) begin
            seen_w = 1'b1;
            last_wb_addr = pmem_address;
            last_wb_line = pmem_wdata;
         end
         if (pmem_read && !seen_r) begin
            seen_r = 1'b1;
            last_al_addr = pmem_address;
         end
         if (mem_resp) begin
            done = 1'b1;
            last_rdata = mem_rdata;
         end else begin
            cyc++;
         end
         @(posedge clk); #2;
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      chk("resp_seen", 256'(done), 256'(1));
      chk("latency", 256'(cyc), 256'(exp_cyc));
      chk("wb_seen", 256'(seen_w), 256'(exp_wb));
      chk("fill_seen", 256'(seen_r), 256'(!exp_hit));
      if (exp_wb) chk("wb_addr", 256'(last_wb_addr), 256'({mt[s], a[7:5], 5'b00000}));
      if (!exp_hit) chk("fill_addr", 256'(last_al_addr), 256'({a[31:5], 5'b00000}));
      md[s] = (exp_hit ? md[s] : 1'b0) | wr;
      mv[s] = 1'b1;
      mt[s] = t;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 8; i++) begin
         mv[i] = 1'b0;
         md[i] = 1'b0;
         mt[i] = '0;
      end
      rst             = 1'b1;
      mem_addr        = 32'h0000_1004;
      mem_read        = 1'b1;
      mem_write       = 1'b0;
      mem_wdata       = '0;
      mem_byte_enable = '0;
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #7;
      chk("rst_resp", 256'(mem_resp), 256'(0));
      chk("rst_pread", 256'(pmem_read), 256'(0));
      chk("rst_pwrite", 256'(pmem_write), 256'(0));
      @(posedge clk); #2;
      mem_read = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #2;

      // cold load, then hits, then a partial store
      access(32'h0000_1004, 1'b0, 32'h0, 4'h0, 0);
      chk("cold_rdata", 256'(last_rdata), 256'(32'hDEAD_BEEF));
      chk("cold_fill_addr", 256'(last_al_addr), 256'(32'h0000_1000));
      access(32'h0000_1004, 1'b0, 32'h0, 4'h0, 0);
      chk("hit_rdata", 256'(last_rdata), 256'(32'hDEAD_BEEF));
      access(32'h0000_1004, 1'b1, 32'h0000_AB00, 4'b0010, 0);
      access(32'h0000_1004, 1'b0, 32'h0, 4'h0, 0);
      chk("reload_rdata", 256'(last_rdata), 256'(32'hDEAD_ABEF));

      // dirty conflict miss in set 0
      access(32'h0000_2004, 1'b0, 32'h0, 4'h0, 0);
      chk("wb_addr_lit", 256'(last_wb_addr), 256'(32'h0000_1000));
      chk("wb_word1_lit", 256'(last_wb_line[63:32]), 256'(32'hDEAD_ABEF));
      chk("fill2_addr_lit", 256'(last_al_addr), 256'(32'h0000_2000));

      // write-allocate into set 1 with a short stall, then a second store and reload
      access(32'h0000_1024, 1'b1, 32'h1122_3344, 4'b1111, 3);
      access(32'h0000_1038, 1'b1, 32'hAABB_CCDD, 4'b1001, 0);
      access(32'h0000_1038, 1'b0, 32'h0, 4'h0, 0);
      chk("be1001_rdata", 256'(last_rdata), 256'(32'hAAC3_10DD));

      // 20-cycle stalls on both writeback and fill
      access(32'h0000_3024, 1'b0, 32'h0, 4'h0, 20);
      chk("stall_wb_addr", 256'(last_wb_addr), 256'(32'h0000_1020));
      access(32'h0000_1024, 1'b0, 32'h0, 4'h0, 0);
      chk("wb_back_rdata", 256'(last_rdata), 256'(32'h1122_3344));

      // set 7: upper-half store, left dirty across the reset below
      access(32'h0000_10E0, 1'b1, 32'h5566_0000, 4'b1100, 0);
      access(32'h0000_10E0, 1'b0, 32'h0, 4'h0, 0);
      chk("be1100_rdata", 256'(last_rdata), 256'(32'h5566_10E0));

      // reset in the middle of a fill
      resp_delay = 50;
      mem_addr   = 32'h0000_3008;
      mem_read   = 1'b1;
      repeat (3) @(posedge clk);
      #7;
      chk("alloc_pread", 256'(pmem_read), 256'(1));
      chk("alloc_addr", 256'(pmem_address), 256'(32'h0000_3000));
      #1 rst = 1'b0;
      #1;
      chk("midrst_pread", 256'(pmem_read), 256'(0));
      chk("midrst_pwrite", 256'(pmem_write), 256'(0));
      chk("midrst_resp", 256'(mem_resp), 256'(0));
      @(posedge clk); #2;
      mem_read = 1'b0;
      @(posedge clk); #2;
      rst        = 1'b1;
      resp_delay = 0;
      for (int i = 0; i < 8; i++) begin
         mv[i] = 1'b0;
         md[i] = 1'b0;
      end
      cm.delete();
      @(posedge clk); #2;

      // everything misses again after reset; unwritten dirty data is gone
      access(32'h0000_2004, 1'b0, 32'h0, 4'h0, 0);
      chk("post_rst_fill", 256'(last_al_addr), 256'(32'h0000_2000));
      chk("post_rst_rdata", 256'(last_rdata), 256'(32'hA5C3_2004));
      access(32'h0000_1004, 1'b0, 32'h0, 4'h0, 0);
      chk("post_rst_1004", 256'(last_rdata), 256'(32'hDEAD_ABEF));
      access(32'h0000_10E4, 1'b0, 32'h0, 4'h0, 0);
      chk("post_rst_10e4", 256'(last_rdata), 256'(32'hA5C3_10E4));

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
